uart_rx_sequencer: RTL and testbench
====================================

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 Parameter FRAME_BITS, default 8: width of received data word, matching the attached receiver.
REQ-002 Parameter FIFO_DEPTH, default 8: receive buffer entries; power of two, minimum 2.
REQ-003 Parameter STALL_CYCLES, default 4096: consecutive busy cycles without converted that raise a stall event.
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  FRAME_BITS  receiver data word.
REQ-007 rx_converted  input  1  receiver frame-complete flag, held until flushed.
REQ-008 rx_data_valid  input  1  receiver parity-good flag, qualified by rx_converted.
REQ-009 rx_busy  input  1  receiver reception-in-progress flag.
REQ-010 rx_flush  output  1  registered one-cycle pulse releasing the receiver.
REQ-011 out_data  output  FRAME_BITS  FIFO head word.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 parity_err, overrun_err, stall_err  output  1 each  one-cycle event pulses.
REQ-016 parity_cnt, overrun_cnt, stall_cnt  output  8 each  saturating event counters (see Configuration).

Function
REQ-017 The FSM SHALL have states WAIT, CAPTURE, FLUSH, DRAIN; reset state WAIT.
REQ-018 WAIT: rx_flush=0; rx_converted=1 -> CAPTURE next cycle.
REQ-019 CAPTURE (one cycle): rx_data_valid=1 and occupancy<FIFO_DEPTH -> push rx_data; rx_data_valid=0 -> discard, pulse parity_err; FIFO full -> discard, pulse overrun_err; always -> FLUSH.
REQ-020 Full test SHALL use occupancy registered before a concurrent pop; push is discarded even if a pop occurs the same cycle.
REQ-021 FLUSH: rx_flush=1 for exactly this cycle -> DRAIN.
REQ-022 DRAIN: rx_flush=0; remain until rx_converted=0, then -> WAIT; no frame is captured twice.
REQ-023 FIFO SHALL be first-word-fall-through: out_data = oldest entry, out_valid = (fifo_count!=0).
REQ-024 Pop occurs when out_valid=1 and out_ready=1; out_ready with empty FIFO is ignored.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-026 Pushed word SHALL appear on out_data with out_valid=1 the cycle after CAPTURE when FIFO was empty (latency rx_converted rise -> out_valid = 2 cycles).
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 Stall counter SHALL increment each cycle rx_busy=1 and rx_converted=0, clear otherwise; on reaching STALL_CYCLES pulse stall_err once and hold until cleared.
REQ-029 Event pulses SHALL be registered, high for exactly one cycle per event.

Reset
REQ-030 On i_rst=1 asynchronously: state=WAIT, rx_flush=0, FIFO empty (pointers 0, fifo_count=0, out_valid=0), out_data=0, all err pulses=0, all counters=0, stall counter=0.
REQ-031 Reset mid-frame SHALL drop all buffered data; after release, a receiver holding rx_converted=1 SHALL be captured normally.

Configuration
REQ-032 Macro UART_RX_SEQ_STATS_EN defined: parity_cnt, overrun_cnt, stall_cnt increment on their pulses, saturate at 255.
REQ-033 Macro undefined: counter logic SHALL be absent, the three counter ports driven constant 0; all other behaviour identical.

Verification
REQ-034 Three frames 0x41,0x42,0x43 with rx_data_valid=1, out_ready=0 -> fifo_count=3, one rx_flush per frame, then out_ready=1 yields 0x41,0x42,0x43 in order.
REQ-035 Frame 0x55 with rx_data_valid=0 -> parity_err one pulse, fifo_count unchanged, rx_flush still pulsed, parity_cnt=1 (macro defined).
REQ-036 FIFO_DEPTH=8 full, ninth frame 0x99 with out_ready=1 in CAPTURE cycle -> 0x99 discarded, overrun_err pulse, fifo_count=7 after pop.
REQ-037 rx_busy=1 held 4096 cycles with rx_converted=0 -> single stall_err pulse on cycle 4096, none after; busy drop then reassert restarts count.
REQ-038 i_rst asserted in DRAIN with fifo_count=5 -> all outputs zero immediately; release with rx_converted=1 -> capture and rx_flush within 3 cycles.
REQ-039 Macro undefined, 300 parity errors -> counter ports remain 0, parity_err pulses 300 times.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// Purpose : bundle of receiver-side and consumer-side signals for uart_rx_sequencer.
// Ports   : slave modport = sequencer view (receiver flags/data and out_ready in; flush, FIFO head, count, events, counters out).
//           master modport = environment view (receiver model plus consumer).
// Note    : FRAME_BITS / FIFO_DEPTH must match the parameters of the attached uart_rx_sequencer.
interface uart_rx_sequencer_if #(
  parameter int FRAME_BITS = 8,
  parameter int FIFO_DEPTH = 8
);
  // receiver side
  logic [FRAME_BITS-1:0]         rx_data;
  logic                          rx_converted;
  logic                          rx_data_valid;
  logic                          rx_busy;
  logic                          rx_flush;
  // consumer side
  logic [FRAME_BITS-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  // events and statistics
  logic                          parity_err;
  logic                          overrun_err;
  logic                          stall_err;
  logic [7:0]                    parity_cnt;
  logic [7:0]                    overrun_cnt;
  logic [7:0]                    stall_cnt;

  modport slave (
    input  rx_data, rx_converted, rx_data_valid, rx_busy, out_ready,
    output rx_flush, out_data, out_valid, fifo_count,
           parity_err, overrun_err, stall_err,
           parity_cnt, overrun_cnt, stall_cnt
  );

  modport master (
    output rx_data, rx_converted, rx_data_valid, rx_busy, out_ready,
    input  rx_flush, out_data, out_valid, fifo_count,
           parity_err, overrun_err, stall_err,
           parity_cnt, overrun_cnt, stall_cnt
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// Purpose : takes completed frames from a UART receiver, buffers good ones in a FWFT FIFO, releases the receiver with a flush pulse.
// Latency : rx_converted rise -> out_valid/out_data after 2 cycles (empty FIFO); rx_flush 2 cycles after rx_converted rise.
// Backpr. : consumer stalls via out_ready; when the FIFO is full at capture the frame is dropped and overrun_err pulses.
// Ports   : i_clk, i_rst (async, active high); bus (uart_rx_sequencer_if.slave) carries receiver flags/data, FIFO head,
//           fifo_count, parity/overrun/stall event pulses and 8-bit event counters.
// Option  : define UART_RX_SEQ_STATS_EN to build the saturating event counters; otherwise the counter ports read 0.
module uart_rx_sequencer #(
  parameter int FRAME_BITS   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_rx_sequencer_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_par_evt;
  logic                  w_ovr_evt;

  logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  r_rx_flush;
  logic                  r_parity_err;
  logic                  r_overrun_err;
  logic                  r_stall_err;

  logic [SW-1:0]         r_stall_run;
  logic                  w_stalling;
  logic                  w_stall_hit;

  // Full is judged on the occupancy registered before this cycle, so a pop
  // in the capture cycle does not rescue a frame arriving at a full FIFO.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && bus.out_ready;

  //--------------------------------------------------------------------------
  // Frame handshake FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_par_evt = 1'b0;
    w_ovr_evt = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (bus.rx_converted) begin
          w_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (!bus.rx_data_valid) begin
          w_par_evt = 1'b1;
        end else if (w_full) begin
          w_ovr_evt = 1'b1;
        end else begin
          w_push = 1'b1;
        end
        w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Wait for the receiver to drop its completion flag so the same
        // frame is never taken twice.
        if (!bus.rx_converted) begin
          w_next = ST_WAIT;
        end
      end
      default: begin
        w_next = ST_WAIT;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Registered outputs: flush strobe and event pulses
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_flush    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_rx_flush    <= (w_next == ST_FLUSH);
      r_parity_err  <= w_par_evt;
      r_overrun_err <= w_ovr_evt;
    end
  end

  //--------------------------------------------------------------------------
  // First-word-fall-through receive FIFO
  //--------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  // Pointers are AW bits wide and FIFO_DEPTH is a power of two, so the
  // natural binary rollover is the modulo-depth wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head word is forced to zero while empty so stale storage never leaks out.
  assign bus.out_data   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.out_valid  = (r_count != '0);
  assign bus.fifo_count = r_count;
  assign bus.rx_flush   = r_rx_flush;

  //--------------------------------------------------------------------------
  // Stall watchdog: counts consecutive busy cycles with no completed frame.
  // The run counter parks at STALL_CYCLES so the event fires exactly once
  // per stall episode.
  //--------------------------------------------------------------------------
  assign w_stalling  = bus.rx_busy && !bus.rx_converted;
  assign w_stall_hit = w_stalling && (r_stall_run == SW'(STALL_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_run <= '0;
      r_stall_err <= 1'b0;
    end else begin
      r_stall_err <= w_stall_hit;
      if (!w_stalling) begin
        r_stall_run <= '0;
      end else if (r_stall_run != SW'(STALL_CYCLES)) begin
        r_stall_run <= r_stall_run + SW'(1);
      end
    end
  end

  assign bus.parity_err  = r_parity_err;
  assign bus.overrun_err = r_overrun_err;
  assign bus.stall_err   = r_stall_err;

  //--------------------------------------------------------------------------
  // Optional saturating event counters, advanced by the registered pulses
  //--------------------------------------------------------------------------
`ifdef UART_RX_SEQ_STATS_EN
  logic [7:0] r_parity_cnt;
  logic [7:0] r_overrun_cnt;
  logic [7:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_parity_cnt  <= '0;
      r_overrun_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (r_parity_err && (r_parity_cnt != 8'hFF)) begin
        r_parity_cnt <= r_parity_cnt + 8'd1;
      end
      if (r_overrun_err && (r_overrun_cnt != 8'hFF)) begin
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      end
      if (r_stall_err && (r_stall_cnt != 8'hFF)) begin
        r_stall_cnt <= r_stall_cnt + 8'd1;
      end
    end
  end

  assign bus.parity_cnt  = r_parity_cnt;
  assign bus.overrun_cnt = r_overrun_cnt;
  assign bus.stall_cnt   = r_stall_cnt;
`else
  assign bus.parity_cnt  = 8'd0;
  assign bus.overrun_cnt = 8'd0;
  assign bus.stall_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: directed frames from a simple receiver stand-in,
// a frame-level reference model checked every cycle, plus literal spot checks.
module tb_uart_rx_sequencer;

  localparam int FB    = 8;
  localparam int DEPTH = 8;
  localparam int STALL = 4096;
`ifdef UART_RX_SEQ_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_sequencer_if #(.FRAME_BITS(FB), .FIFO_DEPTH(DEPTH)) bus ();

  uart_rx_sequencer #(
    .FRAME_BITS  (FB),
    .FIFO_DEPTH  (DEPTH),
    .STALL_CYCLES(STALL)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  //--------------------------------------------------------------------------
  // Reference model. m_step tracks where the current frame is in its life:
  // 0 idle, 1 frame seen and about to be judged, 2 release strobe showing,
  // 3 waiting for the receiver to let go of the frame.
  //--------------------------------------------------------------------------
  logic [FB-1:0] m_q[$];
  int  m_step;
  bit  m_flush, m_par, m_ovr, m_stall;
  int  m_run;
  int  m_pc, m_oc, m_sc;
  bit  m_pop, m_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_step = 0; m_flush = 0; m_par = 0; m_ovr = 0; m_stall = 0;
      m_run = 0; m_pc = 0; m_oc = 0; m_sc = 0;
    end else begin
      if (STATS_EN) begin
        if (m_par   && m_pc < 255) m_pc++;
        if (m_ovr   && m_oc < 255) m_oc++;
        if (m_stall && m_sc < 255) m_sc++;
      end
      m_pop  = (m_q.size() != 0) && bus.out_ready;
      m_full = (m_q.size() == DEPTH);
      m_flush = 0; m_par = 0; m_ovr = 0; m_stall = 0;
      if (m_pop) void'(m_q.pop_front());
      case (m_step)
        0: if (bus.rx_converted) m_step = 1;
        1: begin
          if (!bus.rx_data_valid) m_par = 1;
          else if (m_full)        m_ovr = 1;
          else                    m_q.push_back(bus.rx_data);
          m_flush = 1;
          m_step  = 2;
        end
        2: m_step = 3;
        default: if (!bus.rx_converted) m_step = 0;
      endcase
      if (bus.rx_busy && !bus.rx_converted) begin
        m_run++;
        if (m_run == STALL) m_stall = 1;
      end else begin
        m_run = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rx_flush",    32'(bus.rx_flush),    32'(m_flush));
      chk("parity_err",  32'(bus.parity_err),  32'(m_par));
      chk("overrun_err", 32'(bus.overrun_err), 32'(m_ovr));
      chk("stall_err",   32'(bus.stall_err),   32'(m_stall));
      chk("fifo_count",  32'(bus.fifo_count),  32'(m_q.size()));
      chk("out_valid",   32'(bus.out_valid),   32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", 32'(bus.out_data), 32'(m_q[0]));
      chk("parity_cnt",  32'(bus.parity_cnt),  32'(m_pc));
      chk("overrun_cnt", 32'(bus.overrun_cnt), 32'(m_oc));
      chk("stall_cnt",   32'(bus.stall_cnt),   32'(m_sc));
    end
  end

  // Event tallies (read by the directed sequence, never reset).
  int n_flush = 0, n_par = 0, n_ovr = 0;
  always @(negedge clk) begin
    if (bus.rx_flush)    n_flush++;
    if (bus.parity_err)  n_par++;
    if (bus.overrun_err) n_ovr++;
  end

  //--------------------------------------------------------------------------
  // Stimulus helpers
  //--------------------------------------------------------------------------
  task automatic send_frame(input logic [FB-1:0] d, input logic dv, input bit pop_cap);
    bit seen;
    @(negedge clk);
    bus.rx_data = d; bus.rx_data_valid = dv; bus.rx_converted = 1'b1;
    @(negedge clk);
    if (pop_cap) bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (pop_cap) bus.out_ready = 1'b0;
      if (bus.rx_flush) seen = 1;
    end
    if (!seen) chk("flush_timeout", 32'(seen), 32'd1);
    bus.rx_converted = 1'b0; bus.rx_data_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [FB-1:0] got[$];
  task automatic drain(input int n);
    got.delete();
    bus.out_ready = 1'b1;
    repeat (n) begin
      if (bus.out_valid) got.push_back(bus.out_data);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"}, 32'(bus.rx_flush),   32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid),  32'd0);
    chk({tag, "_data"},  32'(bus.out_data),   32'd0);
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
    chk({tag, "_errs"},  32'({bus.parity_err, bus.overrun_err, bus.stall_err}), 32'd0);
    chk({tag, "_cnts"},  32'({bus.parity_cnt, bus.overrun_cnt, bus.stall_cnt}), 32'd0);
  endtask

  //--------------------------------------------------------------------------
  // Directed sequence
  //--------------------------------------------------------------------------
  int f0, p0, o0, hits, hit_at, k_fl;

  initial begin
    bus.rx_data = '0; bus.rx_converted = 0; bus.rx_data_valid = 0;
    bus.rx_busy = 0;  bus.out_ready = 0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b0;
    @(negedge clk);

    // Three good frames held in the FIFO, first one checked for latency.
    f0 = n_flush;
    bus.rx_data = 8'h41; bus.rx_data_valid = 1; bus.rx_converted = 1;
    @(negedge clk);
    chk("lat_1cyc_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_2cyc_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_2cyc_data",  32'(bus.out_data),  32'h41);
    chk("lat_2cyc_flush", 32'(bus.rx_flush),  32'd1);
    bus.rx_converted = 0; bus.rx_data_valid = 0;
    @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h43, 1'b1, 1'b0);
    chk("three_count",   32'(bus.fifo_count), 32'd3);
    chk("three_flushes", 32'(n_flush - f0),   32'd3);
    drain(6);
    chk("order_len", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("order_0", 32'(got[0]), 32'h41);
      chk("order_1", 32'(got[1]), 32'h42);
      chk("order_2", 32'(got[2]), 32'h43);
    end

    // Parity failure: dropped, flagged, still released.
    f0 = n_flush; p0 = n_par;
    send_frame(8'h55, 1'b0, 1'b0);
    chk("par_pulses", 32'(n_par - p0),     32'd1);
    chk("par_count",  32'(bus.fifo_count), 32'd0);
    chk("par_flush",  32'(n_flush - f0),   32'd1);
    chk("par_cnt",    32'(bus.parity_cnt), STATS_EN ? 32'd1 : 32'd0);

    // Overrun: fill, then a ninth frame with a pop during its capture cycle.
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h10 + i), 1'b1, 1'b0);
    chk("full_count", 32'(bus.fifo_count), 32'd8);
    o0 = n_ovr;
    send_frame(8'h99, 1'b1, 1'b1);
    chk("ovr_pulses", 32'(n_ovr - o0),      32'd1);
    chk("ovr_count",  32'(bus.fifo_count),  32'd7);
    chk("ovr_cnt",    32'(bus.overrun_cnt), STATS_EN ? 32'd1 : 32'd0);
    drain(10);
    chk("ovr_len", 32'(got.size()), 32'd7);
    if (got.size() == 7) begin
      chk("ovr_first", 32'(got[0]), 32'h11);
      chk("ovr_last",  32'(got[6]), 32'h17);
    end

    // Stall watchdog: single pulse on the 4096th busy cycle.
    hits = 0; hit_at = 0;
    bus.rx_busy = 1;
    for (int i = 1; i <= STALL + 100; i++) begin
      @(negedge clk);
      if (bus.stall_err) begin hits++; hit_at = i; end
    end
    chk("stall_hits", 32'(hits),   32'd1);
    chk("stall_when", 32'(hit_at), 32'(STALL));
    bus.rx_busy = 0;
    @(negedge clk);
    bus.rx_busy = 1;
    hits = 0;
    for (int i = 1; i <= STALL - 96; i++) begin
      @(negedge clk);
      if (bus.stall_err) hits++;
    end
    chk("stall_restart", 32'(hits), 32'd0);
    bus.rx_busy = 0;
    @(negedge clk);
    chk("stall_cnt", 32'(bus.stall_cnt), STATS_EN ? 32'd1 : 32'd0);

    // Reset while waiting for the receiver to let go, with five words queued.
    for (int i = 0; i < 4; i++) send_frame(8'(8'h60 + i), 1'b1, 1'b0);
    @(negedge clk);
    bus.rx_data = 8'h64; bus.rx_data_valid = 1; bus.rx_converted = 1;
    repeat (4) @(negedge clk);
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd5);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    bus.rx_data = 8'h77;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    k_fl = 0;
    for (int k = 1; k <= 3 && k_fl == 0; k++) begin
      @(negedge clk);
      if (bus.rx_flush) k_fl = k;
    end
    chk("post_rst_flush_seen", 32'(k_fl != 0), 32'd1);
    bus.rx_converted = 0; bus.rx_data_valid = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_count", 32'(bus.fifo_count), 32'd1);
    chk("post_rst_data",  32'(bus.out_data),   32'h77);
    drain(3);

    // 300 parity failures: pulses every time, counter saturates or stays 0.
    p0 = n_par;
    for (int i = 0; i < 300; i++) send_frame(8'(i), 1'b0, 1'b0);
    chk("par300_pulses", 32'(n_par - p0),     32'd300);
    chk("par300_cnt",    32'(bus.parity_cnt), STATS_EN ? 32'd255 : 32'd0);
    chk("par300_count",  32'(bus.fifo_count), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
